enigma_key_io: RTL

Sequencing front end for the combinational rotor/reflector scrambler. It accepts 5-bit letter codes over a valid/ready stream and turns each one into a single timed one-hot key press on the scrambler's 26-bit input. It then samples the 26-bit lamp response, decodes it back to a 5-bit letter code with error checks, and returns the result over a second valid/ready stream. The block is the encoder on the keyboard side and the decoder on the lampboard side of the scrambler interface. It guarantees exactly one press edge per letter, so the rotors step exactly once per letter.

---
 rtl/enigma_key_io.sv | 117 +++++++++++
 1 files changed

// File: rtl/enigma_key_io.sv
// Keyboard/lampboard sequencer for the rotor scrambler: one timed one-hot press
// per accepted letter, then lamp decode with error flags onto a result stream.
//
// state   | meaning
// IDLE    | waiting for a letter; result register may still be pending
// PRESS   | key held on the scrambler for SETTLE cycles, lamps sampled on the last
// RELEASE | key released for GAP cycles so the next press is a fresh edge
module enigma_key_io #(
    parameter int SETTLE = 2,
    parameter int GAP    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_letter,
    output logic [25:0] key_out,
    input  logic [25:0] lamp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_letter,
    output logic        out_err,
    output logic [15:0] press_count
);

    localparam int CNT_MAX = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    letter;
    logic          accept, legal, cnt_done, capture;
    logic [4:0]    lamp_idx;
    logic          lamp_err;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign legal    = (in_letter <= 5'd25);
    assign cnt_done = (cnt == '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_nxt = PRESS;
                    cnt_nxt   = CW'(SETTLE - 1);
                end
            end
            PRESS: begin
                if (cnt_done) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = CW'(GAP - 1);
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RELEASE: begin
                if (cnt_done) state_nxt = IDLE;
                else          cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lowest set lamp wins; a dark board decodes to 31 and is always an error.
    always_comb begin
        lamp_idx = 5'd31;
        for (int i = 25; i >= 0; i--) begin
            if (lamp_in[i]) lamp_idx = 5'(i);
        end
        lamp_err = ($countones(lamp_in) != 1) || (lamp_idx == letter);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            letter      <= '0;
            key_out     <= '0;
            out_valid   <= 1'b0;
            out_letter  <= '0;
            out_err     <= 1'b0;
            press_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;

            if (accept && legal) begin
                letter      <= in_letter;
                key_out     <= 26'(1) << in_letter;
                press_count <= press_count + 16'd1;
            end else if (capture) begin
                key_out <= '0;
            end

            // A fresh result overrides a handshake in the same cycle.
            if (capture) begin
                out_valid  <= 1'b1;
                out_letter <= lamp_idx;
                out_err    <= lamp_err;
            end else if (accept && !legal) begin
                out_valid  <= 1'b1;
                out_letter <= 5'd31;
                out_err    <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
